// File: rtl/nand_self_test.sv
// Built-in self-test sequencer for a 2-input NAND gate: walks {in1,in2} through
// 00,01,10,11 for ROUNDS passes, samples gate_out after a settle delay and tallies mismatches.
module nand_self_test #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ROUNDS        = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gate_out,
  output logic             in1,
  output logic             in2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);
  localparam logic [7:0] LAST_ROUND  = 8'(ROUNDS - 1);

  state_t     state;
  logic [1:0] vec;
  logic [7:0] round;
  logic [7:0] settle_cnt;
  logic [1:0] next_vec;
  logic       mismatch;

  assign next_vec = vec + 2'd1;
  assign mismatch = (gate_out != ~(in1 & in2));

  // Single sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= 2'd0;
      round      <= 8'd0;
      settle_cnt <= 8'd0;
      in1        <= 1'b0;
      in2        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= 2'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= APPLY;
            vec        <= 2'd0;
            round      <= 8'd0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= 2'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
            in1        <= 1'b0;
            in2        <= 1'b0;
            busy       <= 1'b1;
          end
        end
        APPLY: begin
          settle_cnt <= SETTLE_INIT;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt <= 8'd1) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            if (err_count != '1) begin
              err_count <= err_count + 1'b1;
            end
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= {in1, in2};
            end
          end
          // The final sample's own mismatch must be folded into pass.
          if (vec == 2'd3 && round == LAST_ROUND) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
            in1   <= 1'b0;
            in2   <= 1'b0;
          end else begin
            vec <= next_vec;
            if (vec == 2'd3) begin
              round <= round + 8'd1;
            end
            in1   <= next_vec[1];
            in2   <= next_vec[0];
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nand_self_test.md
Name: nand_self_test

Overview:
- Built-in self-test sequencer that sits directly upstream of the 2-input NAND gate.
- Drives the gate's in1/in2 through all four input vectors, waits a programmable settle time, and samples the gate's out.
- Compares each sample against the expected NAND result, counts mismatches and reports pass/fail through a start/busy/done handshake.
- Lets a board-level controller or test bench qualify the gate without hand-written stimulus.

Parameters:
- SETTLE_CYCLES, 2, cycles between applying a vector and sampling gate_out; legal range 1..255.
- ROUNDS, 1, number of complete passes over the 4-vector table; legal range 1..255.
- ERR_W, 4, width of the mismatch counter.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a test run; sampled only in IDLE or DONE.
- gate_out  input  1  output of the NAND gate under test.
- in1  output  1  registered drive to the gate's in1.
- in2  output  1  registered drive to the gate's in2.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next accepted start or reset.
- pass  output  1  valid when done=1: high iff err_count==0.
- err_count  output  ERR_W  saturating mismatch count for the current or last run.
- fail_valid  output  1  high once any mismatch has been recorded in the current run.
- fail_vec  output  2  {in1,in2} of the first mismatching vector; meaningful only when fail_valid=1.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (clk, rst).
  - While rst=1 at an edge, all outputs are 0 after that edge: in1, in2, busy, done, pass, err_count, fail_valid, fail_vec.
  - State returns to IDLE.
  - Reset mid-run aborts the run; no partial result is kept.
- Internal state: state reg; 2-bit vec; round counter of 8 bits; settle counter of 8 bits.
- IDLE:
  - busy=0; in1=in2=0.
  - start=1 -> APPLY. On the same edge: vec=0, round=0, err_count=0, fail_valid=0, fail_vec=0, done=0, pass=0, in1=0, in2=0.
- APPLY (1 cycle):
  - busy=1; in1/in2 already hold vec[1]/vec[0], loaded on the edge entering APPLY.
  - Load settle counter with SETTLE_CYCLES -> SETTLE.
- SETTLE (exactly SETTLE_CYCLES cycles):
  - Decrement the counter each cycle; when it reaches 1 -> SAMPLE.
  - in1/in2 held stable.
- SAMPLE (1 cycle): expected = ~(in1 & in2).
  - On mismatch: err_count increments, saturating at 2^ERR_W-1.
  - If fail_valid=0, set fail_valid=1 and fail_vec={in1,in2}. Later mismatches do not overwrite fail_vec.
  - If vec==3 and round==ROUNDS-1 -> DONE.
  - Else vec=vec+1, wrapping 3->0. On wrap, round increments. Load the new in1/in2 -> APPLY.
- DONE:
  - busy=0; done=1; pass=(err_count==0).
  - in1=in2=0, cleared on the edge entering DONE.
  - Holds indefinitely. start=1 restarts exactly as from IDLE, and done drops on that same edge.
- start while busy=1 is ignored and has no effect on the run. start held high continuously restarts on every entry to DONE.
- Timing: with start accepted at edge k, each vector occupies SETTLE_CYCLES+2 cycles.
  - DONE is entered at edge k + 4*ROUNDS*(SETTLE_CYCLES+2).
  - Default parameters: k+16.
- Vector order is fixed: 00, 01, 10, 11 for {in1,in2}.
- gate_out is sampled only in SAMPLE; its value in any other state is ignored.
- rst and start both high at the same edge: rst wins.

Test Plan:
- Default params, true NAND on gate_out; rst, then 1-cycle start -> {in1,in2} sequence 00,01,10,11, each held 4 cycles; busy=1 for 16 cycles; done=1, pass=1, err_count=0, fail_valid=0.
- gate_out tied 1 -> done after 16 cycles, err_count=1, fail_valid=1, fail_vec=2'b11, pass=0.
- gate_out tied 0 -> err_count=3, fail_vec=2'b00 (first failure, not last), pass=0.
- ROUNDS=4, ERR_W=2, gate_out=in1&in2 (all vectors mismatch) -> 16 mismatches; err_count saturates at 3, never wraps to 0; done at edge k+64.
- start held high through a run -> no restart while busy; run completes at k+16. A further start in DONE -> done falls on that edge, err_count and fail_valid cleared, new run starts.
- rst pulsed during SETTLE of vector 2 -> at next edge busy=0, in1=in2=0, done=0, err_count=0; state IDLE; a subsequent start runs a full 16-cycle test from vector 00.
